// File: rtl/usr_reg_rd_pkg.sv
// usr_reg_rd_pkg: shared types and constants for the user-register read/write path
package usr_reg_rd_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int          ERR_CNT_W    = 16;

endpackage

// File: rtl/usr_reg_rd_addr_decode.sv
// usr_reg_rd_addr_decode: combinational byte address -> region index and mapped flag
module usr_reg_rd_addr_decode #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_SRC      = 4,
    parameter int REGION_SHIFT = 8,
    localparam int SEL_W       = $clog2(NUM_SRC)
) (
    input  logic [ADDR_WIDTH-1:REGION_SHIFT] addr_i,
    output logic [SEL_W-1:0]                 idx_o,
    output logic                             mapped_o
);

    localparam int NSEL = 1 << SEL_W;
    localparam logic [NSEL-1:0] MAP = {NSEL{1'b1}} >> (NSEL - NUM_SRC);

    assign idx_o    = addr_i[REGION_SHIFT +: SEL_W];
    assign mapped_o = MAP[idx_o] && ~|addr_i[ADDR_WIDTH-1:REGION_SHIFT+SEL_W];

endmodule

// File: rtl/usr_reg_rd_mux.sv
// usr_reg_rd_mux: N-source user-register read mux with unmapped/timeout error termination
// Optional: define USR_REG_RD_MUX_ERR_CNT_EN to add o_err_cnt and o_last_err_addr.
module usr_reg_rd_mux
    import usr_reg_rd_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    NUM_SRC      = 4,
    parameter int                    REGION_SHIFT = 8,
    parameter int                    TIMEOUT_CYC  = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA     = DATA_WIDTH'(ERR_DATA_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rd,
    input  logic [ADDR_WIDTH-1:0]         i_addr,
    output logic                          o_rd_ready,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_rd_err,
    output logic [NUM_SRC-1:0]            o_src_rd,
    output logic [ADDR_WIDTH-1:0]         o_src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
`ifdef USR_REG_RD_MUX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]          o_err_cnt,
    output logic [ADDR_WIDTH-1:0]         o_last_err_addr,
`endif
    input  logic [NUM_SRC-1:0]            i_src_valid
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [SEL_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    err_q;
    logic [NUM_SRC-1:0]      src_rd_q;
    logic [SEL_W-1:0]        dec_idx;
    logic                    dec_mapped;

    usr_reg_rd_addr_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_SRC     (NUM_SRC),
        .REGION_SHIFT(REGION_SHIFT)
    ) u_dec (
        .addr_i  (i_addr[ADDR_WIDTH-1:REGION_SHIFT]),
        .idx_o   (dec_idx),
        .mapped_o(dec_mapped)
    );

    // Request FSM: unmapped requests answer directly; mapped ones strobe, wait, or time out
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            src_rd_q <= '0;
        end else begin
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            src_rd_q <= '0;
            case (state_q)
                IDLE: if (i_rd) begin
                    addr_q <= i_addr;
                    idx_q  <= dec_idx;
                    if (dec_mapped) begin
                        src_rd_q[dec_idx] <= 1'b1;
                        state_q           <= REQ;
                    end else begin
                        data_q  <= ERR_DATA;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                REQ: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (i_src_valid[idx_q]) begin
                    data_q  <= i_src_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_q  <= ERR_DATA;
                    err_q   <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rd_ready = (state_q == IDLE);
    assign o_rd_data  = data_q;
    assign o_rd_valid = valid_q;
    assign o_rd_err   = err_q;
    assign o_src_rd   = src_rd_q;
    assign o_src_addr = addr_q;

`ifdef USR_REG_RD_MUX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [ADDR_WIDTH-1:0] last_err_addr_q;

    // Saturating error-response counter plus the address of the most recent error
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q       <= '0;
            last_err_addr_q <= '0;
        end else if (valid_q && err_q) begin
            err_cnt_q       <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
            last_err_addr_q <= addr_q;
        end
    end

    assign o_err_cnt       = err_cnt_q;
    assign o_last_err_addr = last_err_addr_q;
`endif

endmodule

// File: tb/tb_usr_reg_rd_mux.sv
// tb_usr_reg_rd_mux: randomized and directed self-checking bench for usr_reg_rd_mux
module tb_usr_reg_rd_mux;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_rd = 1'b0;
    logic [AW-1:0]     i_addr = '0;
    logic              o_rd_ready;
    logic [DW-1:0]     o_rd_data;
    logic              o_rd_valid;
    logic              o_rd_err;
    logic [NS-1:0]     o_src_rd;
    logic [AW-1:0]     o_src_addr;
    logic [NS*DW-1:0]  i_src_data = '0;
    logic [NS-1:0]     i_src_valid = '0;
`ifdef USR_REG_RD_MUX_ERR_CNT_EN
    logic [15:0]       o_err_cnt;
    logic [AW-1:0]     o_last_err_addr;
`endif

    int          n_checks = 0;
    int          n_err = 0;
    int          exp_err_cnt = 0;
    logic [31:0] exp_last_err = '0;

    always #5 clk = ~clk;

    usr_reg_rd_mux #(.TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rd           (i_rd),
        .i_addr         (i_addr),
        .o_rd_ready     (o_rd_ready),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_rd_err       (o_rd_err),
        .o_src_rd       (o_src_rd),
        .o_src_addr     (o_src_addr),
        .i_src_data     (i_src_data),
`ifdef USR_REG_RD_MUX_ERR_CNT_EN
        .o_err_cnt      (o_err_cnt),
        .o_last_err_addr(o_last_err_addr),
`endif
        .i_src_valid    (i_src_valid)
    );

    // Reference model: address map and response timing from the block's rules
    function automatic bit is_mapped(input logic [31:0] a);
        return a[31:10] == 22'h0 && int'(a[9:8]) < NS;
    endfunction

    function automatic bit times_out(input int lat);
        return lat < 2 || lat > TO + 1;
    endfunction

    function automatic int exp_cycle(input logic [31:0] a, input int lat);
        if (!is_mapped(a)) return 1;
        return times_out(lat) ? TO + 2 : lat + 1;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_rd_ready === 1'b1) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL wait_ready: o_rd_ready=%b required 1 within 50 cycles", o_rd_ready);
    endtask

    // One read; lat = cycle after accept in which the selected source shows valid
    task automatic do_read(input logic [31:0] a, input int lat, input logic [31:0] d, input int noise);
        int          idx;
        int          ek;
        int          gk;
        logic [31:0] gd;
        logic [31:0] ed;
        logic        ge;
        logic        ee;
        logic        stray;
        logic [NS-1:0] sel;
        logic [NS-1:0] es;
        logic [NS-1:0] s1;
        logic [AW-1:0] sa;
        idx   = int'(a[9:8]);
        sel   = NS'(1) << idx;
        es    = is_mapped(a) ? sel : '0;
        ee    = !is_mapped(a) || times_out(lat);
        ed    = ee ? ERRD : d;
        ek    = exp_cycle(a, lat);
        gk    = -1;
        gd    = '0;
        ge    = 1'b0;
        stray = 1'b0;
        s1    = '0;
        sa    = '0;
        wait_ready();
        i_rd   = 1'b1;
        i_addr = a;
        @(posedge clk);
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            i_rd = 1'b0;
            if (k == 1) begin
                s1 = o_src_rd;
                sa = o_src_addr;
            end else if (o_src_rd !== '0) stray = 1'b1;
            if (o_rd_valid === 1'b1) begin
                gk = k;
                gd = o_rd_data;
                ge = o_rd_err;
                break;
            end
            i_src_valid = ((noise == 2) ? {NS{1'b1}} : (noise == 1) ? NS'($urandom) : '0) & ~sel;
            if (k == lat) i_src_valid = i_src_valid | sel;
            i_src_data = {$urandom, $urandom, $urandom, $urandom};
            i_src_data[idx*DW +: DW] = d;
        end
        i_src_valid = '0;
        n_checks++;
        if (s1 !== es) begin n_err++; $display("FAIL strobe addr=%h: got %b want %b", a, s1, es); end
        n_checks++;
        if (is_mapped(a) && sa !== a) begin n_err++; $display("FAIL src_addr: got %h want %h", sa, a); end
        n_checks++;
        if (stray) begin n_err++; $display("FAIL strobe_len addr=%h: strobe seen after cycle 1", a); end
        n_checks++;
        if (gk != ek) begin n_err++; $display("FAIL latency addr=%h lat=%0d: got %0d want %0d", a, lat, gk, ek); end
        n_checks++;
        if (gd !== ed) begin n_err++; $display("FAIL data addr=%h: got %h want %h", a, gd, ed); end
        n_checks++;
        if (ge !== ee) begin n_err++; $display("FAIL err addr=%h: got %b want %b", a, ge, ee); end
        if (ee) begin
            exp_err_cnt++;
            exp_last_err = a;
        end
        @(negedge clk);
        n_checks++;
        if (o_rd_valid !== 1'b0 || o_rd_ready !== 1'b1)
            begin n_err++; $display("FAIL post_resp: valid=%b ready=%b want 0/1", o_rd_valid, o_rd_ready); end
    endtask

    task automatic check_idle_zero(input string tag);
        n_checks++;
        if (o_rd_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_rd_err !== 1'b0 || o_src_rd !== '0 ||
            o_rd_data !== '0 || o_src_addr !== '0) begin
            n_err++;
            $display("FAIL %s: ready=%b valid=%b err=%b src_rd=%b data=%h src_addr=%h want 1/0/0/0/0/0",
                     tag, o_rd_ready, o_rd_valid, o_rd_err, o_src_rd, o_rd_data, o_src_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset_state");
    endtask

    task automatic test_directed();
        do_read(32'h0000_0104, 2, 32'h1234_5678, 0);
        do_read(32'h0001_0000, 2, 32'h1111_1111, 0);
        do_read(32'h0000_0200, 1000, 32'h2222_2222, 0);
        do_read(32'h0000_0200, TO + 1, 32'h3333_3333, 0);
        do_read(32'h0000_0200, 1, 32'h4444_4444, 0);
        do_read(32'h0000_0300, 5, 32'h5555_AAAA, 2);
        do_read(32'h8000_0000, 2, 32'h6666_6666, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int r;
        int lat;
        for (int n = 0; n < 25; n++) begin
            a = {22'h0, 2'($urandom_range(0, 3)), 8'($urandom)};
            if ($urandom_range(0, 7) == 0) a[10 + $urandom_range(0, 21)] = 1'b1;
            r = $urandom_range(0, 9);
            lat = (r < 7) ? $urandom_range(2, TO + 1) : (r < 8) ? TO + 1 : (r < 9) ? 1000 : 1;
            do_read(a, lat, $urandom, $urandom_range(0, 2));
        end
    endtask

    // i_rd held high across A then B; B must wait for A's response cycle to pass
    task automatic test_back_to_back();
        int rA;
        int accB;
        int sB;
        int rB;
        logic [NS-1:0] es;
        wait_ready();
        rA   = 3;
        accB = rA + 1;
        sB   = accB + 1;
        rB   = accB + 3;
        i_rd   = 1'b1;
        i_addr = 32'h0000_0100;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) i_addr = 32'h0000_0300;
            if (c == sB) i_rd = 1'b0;
            es = (c == 1) ? 4'b0010 : (c == sB) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (o_src_rd !== es || o_rd_valid !== (c == rA || c == rB) || o_rd_ready !== (c == accB || c == 8)) begin
                n_err++;
                $display("FAIL b2b cycle %0d: src_rd=%b valid=%b ready=%b want %b/%b/%b", c, o_src_rd, o_rd_valid,
                         o_rd_ready, es, c == rA || c == rB, c == accB || c == 8);
            end
            if (c == rA || c == rB) begin
                n_checks++;
                if (o_rd_data !== ((c == rA) ? 32'hA0A0_0001 : 32'hB0B0_0003) || o_rd_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b data cycle %0d: got %h/%b", c, o_rd_data, o_rd_err);
                end
            end
            i_src_data  = {32'hB0B0_0003, 32'h0, 32'hA0A0_0001, 32'h0};
            i_src_valid = (c == 2) ? 4'b0010 : (c == accB + 2) ? 4'b1000 : 4'b0000;
        end
        i_src_valid = '0;
    endtask

    task automatic test_reset_mid();
        wait_ready();
        i_rd   = 1'b1;
        i_addr = 32'h0000_0200;
        @(posedge clk);
        repeat (4) @(negedge clk);
        i_rd = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err_cnt  = 0;
        exp_last_err = '0;
        check_idle_zero("reset_mid");
        i_src_data  = {32'h0, 32'h7777_7777, 32'h0, 32'h0};
        i_src_valid = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_rd_valid !== 1'b0 || o_rd_ready !== 1'b1 || o_src_rd !== '0) begin
                n_err++;
                $display("FAIL late_valid cycle %0d: valid=%b ready=%b src_rd=%b want 0/1/0", c, o_rd_valid,
                         o_rd_ready, o_src_rd);
            end
        end
        i_src_valid = '0;
    endtask

    task automatic test_err_cnt();
        do_read(32'h0002_0000, 2, 32'h0, 0);
        do_read(32'h0000_0100, 1000, 32'h0, 1);
        do_read(32'h0400_0300, 2, 32'h0, 0);
`ifdef USR_REG_RD_MUX_ERR_CNT_EN
        n_checks++;
        if (o_err_cnt !== 16'(exp_err_cnt)) begin
            n_err++;
            $display("FAIL err_cnt: got %0d want %0d", o_err_cnt, exp_err_cnt);
        end
        n_checks++;
        if (o_last_err_addr !== exp_last_err) begin
            n_err++;
            $display("FAIL last_err_addr: got %h want %h", o_last_err_addr, exp_last_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_err_cnt();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/usr_reg_rd_mux.md
Name: usr_reg_rd_mux

Overview:
- Parametrised N-source read multiplexer for the CPU user-register read path.
- Decodes the read address into one of NUM_SRC register regions (status, control, DMA, ...).
- Issues a one-cycle read strobe to the selected source and waits for that source's valid.
- Returns data with a valid/error response. Unmapped addresses and unresponsive sources are terminated with an error, so the CPU never hangs.

Parameters:
- DATA_WIDTH, 32, width of read data.
- ADDR_WIDTH, 32, width of read address.
- NUM_SRC, 4, number of register sources, 2..16.
- REGION_SHIFT, 8, log2 of the region size in bytes; region index is addr[REGION_SHIFT +: SEL_W].
- TIMEOUT_CYC, 64, maximum WAIT cycles before an error response, >=2.
- ERR_DATA, 32'hDEAD_BEEF, data returned on any error response.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_rd  in  1  read request; accepted only when o_rd_ready=1
- i_addr  in  ADDR_WIDTH  read byte address
- o_rd_ready  out  1  block idle; able to accept i_rd
- o_rd_data  out  DATA_WIDTH  response data, meaningful only when o_rd_valid=1
- o_rd_valid  out  1  one-cycle response pulse
- o_rd_err  out  1  qualifies o_rd_valid: unmapped region or timeout
- o_src_rd  out  NUM_SRC  one-hot, one-cycle read strobe to the selected source
- o_src_addr  out  ADDR_WIDTH  latched request address, held stable from strobe until response
- i_src_data  in  NUM_SRC*DATA_WIDTH  packed source data; source k occupies [k*DATA_WIDTH +: DATA_WIDTH]
- i_src_valid  in  NUM_SRC  source data valid, one bit per source

Behaviour:

Decode:
- SEL_W = $clog2(NUM_SRC).
- idx = i_addr[REGION_SHIFT +: SEL_W].
- The request is mapped iff idx < NUM_SRC and i_addr[ADDR_WIDTH-1 : REGION_SHIFT+SEL_W] == 0.

FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: o_rd_ready=1. On i_rd, latch addr, idx and the mapped flag.
  - Mapped -> REQ.
  - Unmapped -> RESP with err=1, data=ERR_DATA.
- REQ: o_src_rd[idx]=1 for exactly this cycle; clear the timeout counter -> WAIT.
- WAIT: each cycle, sample i_src_valid[idx]; valid bits of non-selected sources are ignored.
  - If set, capture i_src_data[idx], err=0 -> RESP.
  - Otherwise increment the counter. When counter == TIMEOUT_CYC-1 without valid, data=ERR_DATA, err=1 -> RESP.
  - A valid arriving on the same cycle as the timeout takes priority: the response is a success.
- RESP: o_rd_valid=1 for one cycle with o_rd_data/o_rd_err -> IDLE.

Latency:
- Request accepted at edge T; strobe high in cycle T+1.
- Source valid in cycle W >= T+2 gives the response in cycle W+1; minimum 3 cycles.
- Unmapped request: response in cycle T+1.
- Timeout: response in cycle T+2+TIMEOUT_CYC.

Handshake and ordering:
- i_rd while o_rd_ready=0 is ignored (not queued); the requester must hold i_rd until it is accepted.
- Back-to-back reads: the next request can be accepted in the cycle after RESP, since the FSM is back in IDLE.

Reset:
- rst forces IDLE, o_rd_ready=1 (from the cycle after reset), and o_rd_valid=0, o_rd_err=0, o_src_rd=0, o_rd_data=0, o_src_addr=0.
- Reset mid-transaction aborts the transaction with no response. A late source valid after reset is ignored.

Timing:
- o_rd_data, o_rd_valid, o_rd_err and o_src_rd are registered outputs.
- No combinational path from any input to any output.

Optional Feature:
- Macro: USR_REG_RD_MUX_ERR_CNT_EN.
- Defined:
  - Adds output o_err_cnt, 16 bits, saturating at 16'hFFFF, reset to 0.
  - Increments by 1 on every response with o_rd_err=1, covering both unmapped and timeout.
  - Adds output o_last_err_addr, ADDR_WIDTH bits, reset 0, loaded with the latched address on each error response.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package usr_reg_rd_pkg holds:
  - the state typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP};
  - the default ERR_DATA constant;
  - the error-counter width localparam (16).
- One sub-module, usr_reg_rd_addr_decode: purely combinational addr -> {idx, mapped}, parametrised by ADDR_WIDTH, NUM_SRC and REGION_SHIFT. It is reused by the write-path switch.

Test Plan:
- Mapped read, fast source: addr=0x0000_0104 (idx 1), source 1 returns 0x1234_5678 two cycles after accept -> o_src_rd=4'b0010 one cycle; o_rd_valid at T+3 with data 0x1234_5678, err=0.
- Unmapped address: addr=0x0001_0000, or idx 3 with NUM_SRC=3 -> no strobe; o_rd_valid at T+1, data 0xDEAD_BEEF, err=1.
- Timeout: source 2 never asserts valid, TIMEOUT_CYC=8 -> response at T+10, data 0xDEAD_BEEF, err=1. Valid on the 8th WAIT cycle instead gives a success response.
- Cross-source isolation: source 0 valid pulses while idx=3 is pending -> ignored; only source 3 valid completes the read.
- Back-to-back and busy behaviour: i_rd held high with addresses A then B -> B accepted only after A's RESP; two separate responses, each strobe one-hot and a single cycle.
- Reset mid-WAIT, then a late source valid -> no o_rd_valid; o_rd_ready=1 from the cycle after reset. With USR_REG_RD_MUX_ERR_CNT_EN, three errors -> o_err_cnt=3 and o_last_err_addr equal to the third error's address.
